// File: rtl/riscv_inst_decode_stage_if.sv
// Fetch-to-execute bus of the decode stage: instruction handshake in, decoded entry out.
// Signal names carry the direction as seen from the decode stage.
interface riscv_inst_decode_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             inst_valid_i;
  logic             inst_ready_o;
  logic [31:0]      inst_i;
  logic [31:0]      pc_i;
  logic             flush_i;
  logic             dec_valid_o;
  logic             dec_ready_i;
  logic [6:0]       dec_opcode_o;
  logic [4:0]       dec_rd_o;
  logic [4:0]       dec_rs1_o;
  logic [4:0]       dec_rs2_o;
  logic [2:0]       dec_funct3_o;
  logic [6:0]       dec_funct7_o;
  logic [31:0]      dec_imm_o;
  logic [31:0]      dec_pc_o;
  logic             dec_illegal_o;
  logic [CNT_W-1:0] dec_count_o;

  // Environment side: drives fetch and downstream ready, observes decoded entries.
  modport master (
    output inst_valid_i, inst_i, pc_i, flush_i, dec_ready_i,
    input  inst_ready_o, dec_valid_o, dec_opcode_o, dec_rd_o, dec_rs1_o, dec_rs2_o,
           dec_funct3_o, dec_funct7_o, dec_imm_o, dec_pc_o, dec_illegal_o, dec_count_o
  );

  // Decode stage side.
  modport slave (
    input  inst_valid_i, inst_i, pc_i, flush_i, dec_ready_i,
    output inst_ready_o, dec_valid_o, dec_opcode_o, dec_rd_o, dec_rs1_o, dec_rs2_o,
           dec_funct3_o, dec_funct7_o, dec_imm_o, dec_pc_o, dec_illegal_o, dec_count_o
  );
endinterface

// File: rtl/riscv_inst_decode_stage.sv
// RISC-V decode stage: combinational field/immediate decode into a 2-entry output FIFO,
// registered upstream ready, flush, and a saturating handshake counter.
module riscv_inst_decode_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  riscv_inst_decode_stage_if.slave       bus
);

  localparam logic [6:0] OpR    = 7'h33;
  localparam logic [6:0] OpImm  = 7'h13;
  localparam logic [6:0] OpSt   = 7'h23;
  localparam logic [6:0] OpBr   = 7'h63;
  localparam logic [6:0] OpAuip = 7'h17;
  localparam logic [6:0] OpJal  = 7'h6F;
  localparam logic [6:0] OpCust = 7'h0B;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

  logic [31:0] inst;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill;
  dec_t        dec_in;

  assign inst = bus.inst_i;
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];

  always_comb begin
    dec_in        = '0;
    ill           = 1'b0;
    dec_in.opcode = inst[6:0];
    dec_in.pc     = bus.pc_i;
    case (inst[6:0])
      OpR: begin
        dec_in.rd     = inst[11:7];
        dec_in.rs1    = inst[19:15];
        dec_in.rs2    = inst[24:20];
        dec_in.funct3 = f3;
        dec_in.funct7 = f7;
        ill = !(f7 == 7'h00 || f7 == 7'h20) ||
              (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
      end
      OpImm: begin
        dec_in.rd     = inst[11:7];
        dec_in.rs1    = inst[19:15];
        dec_in.funct3 = f3;
        dec_in.imm    = {{20{inst[31]}}, inst[31:20]};
        // Shifts expose funct7 because it selects logical vs arithmetic.
        if (f3 == 3'b001 || f3 == 3'b101) dec_in.funct7 = f7;
        ill = (f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OpSt: begin
        dec_in.rs1    = inst[19:15];
        dec_in.rs2    = inst[24:20];
        dec_in.funct3 = f3;
        dec_in.imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ill = (f3 > 3'b010);
      end
      OpBr: begin
        dec_in.rs1    = inst[19:15];
        dec_in.rs2    = inst[24:20];
        dec_in.funct3 = f3;
        dec_in.imm    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        ill = (f3 == 3'b010 || f3 == 3'b011);
      end
      OpAuip: begin
        dec_in.rd  = inst[11:7];
        dec_in.imm = {inst[31:12], 12'b0};
      end
      OpJal: begin
        dec_in.rd  = inst[11:7];
        dec_in.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OpCust: begin
        dec_in.rd     = inst[11:7];
        dec_in.rs1    = inst[19:15];
        dec_in.rs2    = inst[24:20];
        dec_in.funct3 = f3;
        ill = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec_in         = '0;
      dec_in.opcode  = inst[6:0];
      dec_in.pc      = bus.pc_i;
      dec_in.illegal = 1'b1;
    end
  end

  dec_t             mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, pop, valid;
  dec_t             head;

  assign valid  = (occ_q != 2'd0);
  assign accept = bus.inst_valid_i && ready_q && !bus.flush_i;
  assign pop    = valid && bus.dec_ready_i && !bus.flush_i;

  always_comb begin
    occ_d = occ_q;
    if (bus.flush_i)          occ_d = 2'd0;
    else if (accept && !pop)  occ_d = occ_q + 2'd1;
    else if (pop && !accept)  occ_d = occ_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d < 2'd2);
      if (bus.flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (accept) wr_ptr_q <= ~wr_ptr_q;
        if (pop)    rd_ptr_q <= ~rd_ptr_q;
      end
      if (pop && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= dec_in;
  end

  // Fields are forced to zero whenever no entry is held, so reset/flush show all-zero outputs.
  assign head = valid ? mem_q[rd_ptr_q] : '0;

  assign bus.inst_ready_o  = ready_q;
  assign bus.dec_valid_o   = valid;
  assign bus.dec_opcode_o  = head.opcode;
  assign bus.dec_rd_o      = head.rd;
  assign bus.dec_rs1_o     = head.rs1;
  assign bus.dec_rs2_o     = head.rs2;
  assign bus.dec_funct3_o  = head.funct3;
  assign bus.dec_funct7_o  = head.funct7;
  assign bus.dec_imm_o     = head.imm;
  assign bus.dec_pc_o      = head.pc;
  assign bus.dec_illegal_o = head.illegal;
  assign bus.dec_count_o   = cnt_q;

endmodule

// File: tb/tb_riscv_inst_decode_stage.sv
// Self-checking bench for riscv_inst_decode_stage: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_riscv_inst_decode_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } dec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  riscv_inst_decode_stage_if #(.CNT_W(16)) bus ();
  riscv_inst_decode_stage #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Narrow-counter instance so saturation is reachable in a few cycles.
  riscv_inst_decode_stage_if #(.CNT_W(4)) sbus ();
  riscv_inst_decode_stage #(.CNT_W(4)) dut_s (.clk(clk), .rst(rst), .bus(sbus));

  function automatic dec_t obs();
    dec_t d;
    d.opcode = bus.dec_opcode_o;
    d.rd     = bus.dec_rd_o;
    d.rs1    = bus.dec_rs1_o;
    d.rs2    = bus.dec_rs2_o;
    d.f3     = bus.dec_funct3_o;
    d.f7     = bus.dec_funct7_o;
    d.imm    = bus.dec_imm_o;
    d.pc     = bus.dec_pc_o;
    d.ill    = bus.dec_illegal_o;
    return d;
  endfunction

  function automatic dec_t mk(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] pc, input logic ill);
    dec_t d;
    d.opcode = opc; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.f3 = f3; d.f7 = f7;
    d.imm = imm; d.pc = pc; d.ill = ill;
    return d;
  endfunction

  // Reference decode: classify the format, apply the legality rules, then pick which fields exist.
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit r, i, s, b, u, j, c, bad;
    logic [31:0] imm;
    r = (opc == 7'h33); i = (opc == 7'h13); s = (opc == 7'h23); b = (opc == 7'h63);
    u = (opc == 7'h17); j = (opc == 7'h6F); c = (opc == 7'h0B);
    bad = !(r || i || s || b || u || j || c);
    if (r && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1;
    if (r && f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)) bad = 1;
    if (i && f3 == 3'd1 && f7 != 7'h00) bad = 1;
    if (i && f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1;
    if (s && f3 > 3'd2) bad = 1;
    if (b && (f3 == 3'd2 || f3 == 3'd3)) bad = 1;
    if (c && f3 != 3'd0) bad = 1;
    imm = 32'd0;
    if (i) imm = $signed(w) >>> 20;
    if (s) imm = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
    if (b) imm = $signed({w[31], w[7], w[30:25], w[11:8], 20'b0}) >>> 19;
    if (u) imm = {w[31:12], 12'b0};
    if (j) imm = $signed({w[31], w[19:12], w[20], w[30:21], 12'b0}) >>> 11;
    d = '0;
    d.opcode = opc;
    d.pc = pc;
    if (bad) d.ill = 1'b1;
    else begin
      if (r || i || u || j || c) d.rd = w[11:7];
      if (r || i || s || b || c) d.rs1 = w[19:15];
      if (r || s || b || c) d.rs2 = w[24:20];
      if (r || i || s || b || c) d.f3 = f3;
      if (r || (i && (f3 == 3'd1 || f3 == 3'd5))) d.f7 = f7;
      d.imm = imm;
    end
    return d;
  endfunction

  task automatic idle_inputs();
    bus.inst_valid_i = 0; bus.inst_i = 0; bus.pc_i = 0; bus.flush_i = 0; bus.dec_ready_i = 0;
    sbus.inst_valid_i = 0; sbus.inst_i = 0; sbus.pc_i = 0; sbus.flush_i = 0;
    sbus.dec_ready_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    checks++;
    if (obs() !== '0 || bus.dec_valid_o !== 0 || bus.inst_ready_o !== 0 ||
        bus.dec_count_o !== 0) begin
      $display("FAIL reset_outputs: got fields=%h valid=%b ready=%b count=%0d required all 0",
               obs(), bus.dec_valid_o, bus.inst_ready_o, bus.dec_count_o);
      failures++;
    end
    rst = 0;
    tick();
    checks++;
    if (bus.inst_ready_o !== 1 || bus.dec_valid_o !== 0) begin
      $display("FAIL reset_release: got ready=%b valid=%b required ready=1 valid=0",
               bus.inst_ready_o, bus.dec_valid_o);
      failures++;
    end
  endtask

  task automatic test_addi();
    dec_t exp;
    do_reset();
    bus.dec_ready_i = 1; bus.inst_valid_i = 1; bus.inst_i = 32'hFFF10093; bus.pc_i = 32'h100;
    tick();
    bus.inst_valid_i = 0;
    exp = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'h100, 1'b0);
    checks++;
    if (bus.dec_valid_o !== 1 || obs() !== exp) begin
      $display("FAIL addi: got valid=%b fields=%h required valid=1 fields=%h",
               bus.dec_valid_o, obs(), exp);
      failures++;
    end
    tick();
    checks++;
    if (bus.dec_count_o !== 16'd1 || bus.dec_valid_o !== 0) begin
      $display("FAIL addi_count: got count=%0d valid=%b required count=1 valid=0",
               bus.dec_count_o, bus.dec_valid_o);
      failures++;
    end
  endtask

  task automatic test_store_jal();
    dec_t exp;
    do_reset();
    bus.dec_ready_i = 1; bus.inst_valid_i = 1; bus.inst_i = 32'hFE532E23; bus.pc_i = 32'h104;
    tick();
    exp = mk(7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'hFFFFFFFC, 32'h104, 1'b0);
    checks++;
    if (obs() !== exp) begin
      $display("FAIL sw: got %h required %h", obs(), exp);
      failures++;
    end
    bus.inst_i = 32'h001000EF; bus.pc_i = 32'h108;
    tick();
    bus.inst_valid_i = 0;
    exp = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h108, 1'b0);
    checks++;
    if (bus.dec_valid_o !== 1 || obs() !== exp) begin
      $display("FAIL jal: got valid=%b fields=%h required valid=1 fields=%h",
               bus.dec_valid_o, obs(), exp);
      failures++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    dec_t ea, eb, ec;
    do_reset();
    ea = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'h200, 1'b0);
    eb = mk(7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'hFFFFFFFC, 32'h204, 1'b0);
    ec = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h208, 1'b0);
    bus.dec_ready_i = 0;
    bus.inst_valid_i = 1; bus.inst_i = 32'hFFF10093; bus.pc_i = 32'h200;
    tick();
    bus.inst_i = 32'hFE532E23; bus.pc_i = 32'h204;
    tick();
    bus.inst_i = 32'h001000EF; bus.pc_i = 32'h208;
    checks++;
    if (bus.inst_ready_o !== 0 || obs() !== ea) begin
      $display("FAIL bp_full: got ready=%b head=%h required ready=0 head=%h",
               bus.inst_ready_o, obs(), ea);
      failures++;
    end
    tick();
    checks++;
    if (bus.inst_ready_o !== 0 || obs() !== ea) begin
      $display("FAIL bp_hold: got ready=%b head=%h required ready=0 head=%h",
               bus.inst_ready_o, obs(), ea);
      failures++;
    end
    bus.dec_ready_i = 1;
    tick();
    checks++;
    if (bus.inst_ready_o !== 1 || obs() !== eb) begin
      $display("FAIL bp_second: got ready=%b head=%h required ready=1 head=%h",
               bus.inst_ready_o, obs(), eb);
      failures++;
    end
    tick();
    bus.inst_valid_i = 0;
    checks++;
    if (bus.dec_valid_o !== 1 || obs() !== ec) begin
      $display("FAIL bp_third: got valid=%b head=%h required valid=1 head=%h",
               bus.dec_valid_o, obs(), ec);
      failures++;
    end
    tick();
    checks++;
    if (bus.dec_count_o !== 16'd3 || bus.dec_valid_o !== 0) begin
      $display("FAIL bp_count: got count=%0d valid=%b required count=3 valid=0",
               bus.dec_count_o, bus.dec_valid_o);
      failures++;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] insts [3];
    dec_t exp;
    insts[0] = 32'h00000000; insts[1] = 32'h40001013; insts[2] = 32'h0000200B;
    do_reset();
    bus.dec_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      bus.inst_valid_i = 1; bus.inst_i = insts[k]; bus.pc_i = 32'h300 + 32'(4 * k);
      tick();
      exp = mk(insts[k][6:0], 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h300 + 32'(4 * k), 1'b1);
      checks++;
      if (bus.dec_valid_o !== 1 || obs() !== exp) begin
        $display("FAIL illegal_%0d: got valid=%b fields=%h required valid=1 fields=%h",
                 k, bus.dec_valid_o, obs(), exp);
        failures++;
      end
    end
    bus.inst_valid_i = 0;
    tick();
    checks++;
    if (bus.dec_count_o !== 16'd3) begin
      $display("FAIL illegal_count: got %0d required 3", bus.dec_count_o);
      failures++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.dec_ready_i = 0;
    bus.inst_valid_i = 1; bus.inst_i = 32'hFFF10093; bus.pc_i = 32'h400;
    tick();
    bus.pc_i = 32'h404;
    tick();
    bus.flush_i = 1; bus.dec_ready_i = 1; bus.inst_i = 32'h001000EF; bus.pc_i = 32'h408;
    tick();
    bus.flush_i = 0; bus.inst_valid_i = 0;
    checks++;
    if (bus.dec_valid_o !== 0 || bus.inst_ready_o !== 1 || bus.dec_count_o !== 16'd0) begin
      $display("FAIL flush: got valid=%b ready=%b count=%0d required valid=0 ready=1 count=0",
               bus.dec_valid_o, bus.inst_ready_o, bus.dec_count_o);
      failures++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.dec_valid_o !== 0 || bus.dec_count_o !== 16'd0) begin
        $display("FAIL flush_drop_%0d: got valid=%b count=%0d required valid=0 count=0",
                 k, bus.dec_valid_o, bus.dec_count_o);
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.dec_ready_i = 1;
    bus.inst_valid_i = 1; bus.inst_i = 32'hFFF10093; bus.pc_i = 32'h500;
    tick();
    bus.pc_i = 32'h504;
    tick();
    bus.dec_ready_i = 0; bus.pc_i = 32'h508;
    tick();
    checks++;
    if (bus.inst_ready_o !== 0 || bus.dec_count_o !== 16'd1) begin
      $display("FAIL midrst_setup: got ready=%b count=%0d required ready=0 count=1",
               bus.inst_ready_o, bus.dec_count_o);
      failures++;
    end
    idle_inputs();
    rst = 1;
    tick();
    checks++;
    if (obs() !== '0 || bus.dec_valid_o !== 0 || bus.inst_ready_o !== 0 ||
        bus.dec_count_o !== 0) begin
      $display("FAIL midrst: got fields=%h valid=%b ready=%b count=%0d required all 0",
               obs(), bus.dec_valid_o, bus.inst_ready_o, bus.dec_count_o);
      failures++;
    end
    rst = 0;
    tick();
    checks++;
    if (bus.inst_ready_o !== 1 || bus.dec_valid_o !== 0) begin
      $display("FAIL midrst_release: got ready=%b valid=%b required ready=1 valid=0",
               bus.inst_ready_o, bus.dec_valid_o);
      failures++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    sbus.dec_ready_i = 1; sbus.inst_valid_i = 1; sbus.inst_i = 32'hFFF10093; sbus.pc_i = 0;
    for (int k = 0; k < 16; k++) tick();
    checks++;
    if (sbus.dec_count_o !== 4'hF) begin
      $display("FAIL sat_reach: got %0d required 15", sbus.dec_count_o);
      failures++;
    end
    tick();
    tick();
    sbus.inst_valid_i = 0;
    checks++;
    if (sbus.dec_count_o !== 4'hF) begin
      $display("FAIL sat_hold: got %0d required 15", sbus.dec_count_o);
      failures++;
    end
    tick();
  endtask

  task automatic test_random();
    dec_t q[$];
    bit exp_ready, acc, pop;
    int exp_cnt;
    logic [31:0] w;
    do_reset();
    exp_ready = 1;
    exp_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      case ($urandom_range(0, 7))
        0: w[6:0] = 7'h33;
        1: w[6:0] = 7'h13;
        2: w[6:0] = 7'h23;
        3: w[6:0] = 7'h63;
        4: w[6:0] = 7'h17;
        5: w[6:0] = 7'h6F;
        6: w[6:0] = 7'h0B;
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      bus.inst_i       = w;
      bus.pc_i         = $urandom & 32'hFFFF_FFFC;
      bus.inst_valid_i = ($urandom_range(0, 3) != 0);
      bus.dec_ready_i  = ($urandom_range(0, 3) != 0);
      bus.flush_i      = ($urandom_range(0, 39) == 0);
      acc = bus.inst_valid_i && exp_ready && !bus.flush_i;
      pop = (q.size() > 0) && bus.dec_ready_i && !bus.flush_i;
      tick();
      if (bus.flush_i) q.delete();
      else begin
        if (pop) begin
          void'(q.pop_front());
          if (exp_cnt < 65535) exp_cnt++;
        end
        if (acc) q.push_back(ref_decode(bus.inst_i, bus.pc_i));
      end
      exp_ready = (q.size() < 2);
      checks++;
      if (bus.dec_valid_o !== (q.size() > 0) || bus.inst_ready_o !== exp_ready ||
          bus.dec_count_o !== 16'(exp_cnt)) begin
        $display("FAIL rand_ctrl@%0d: got valid=%b ready=%b count=%0d required %b %b %0d",
                 n, bus.dec_valid_o, bus.inst_ready_o, bus.dec_count_o,
                 (q.size() > 0), exp_ready, exp_cnt);
        failures++;
      end
      if (q.size() > 0) begin
        checks++;
        if (obs() !== q[0]) begin
          $display("FAIL rand_head@%0d: got %h required %h", n, obs(), q[0]);
          failures++;
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_addi();
    test_store_jal();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_inst_decode_stage.md
Name: riscv_inst_decode_stage

Overview:
Pipeline stage that takes raw 32-bit RISC-V instruction words from fetch and produces registered decoded fields for the execute stage. Covered encodings: R, I (ALU immediates), S, B, U (AUIPC), J (JAL) and custom-0. Valid/ready on both sides, with a 2-entry output buffer so neither ready path is combinational. It also detects illegal encodings and counts decoded instructions for the verification environment's coverage.

Parameters:
CNT_W, 16, width of the decoded-instruction counter (saturating)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
inst_valid_i  input  1  upstream instruction valid
inst_ready_o  output  1  stage can accept an instruction this cycle
inst_i  input  32  raw instruction word
pc_i  input  32  address of inst_i
flush_i  input  1  discard all buffered and incoming instructions
dec_valid_o  output  1  decoded entry valid
dec_ready_i  input  1  downstream accepts decoded entry
dec_opcode_o  output  7  inst[6:0]
dec_rd_o  output  5  inst[11:7]; 0 for S/B
dec_rs1_o  output  5  inst[19:15]; 0 for U/J
dec_rs2_o  output  5  inst[24:20]; 0 for I/U/J
dec_funct3_o  output  3  inst[14:12]; 0 for U/J
dec_funct7_o  output  7  inst[31:25] for R and I shifts, else 0
dec_imm_o  output  32  sign-extended immediate
dec_pc_o  output  32  pc of the entry
dec_illegal_o  output  1  entry is an illegal encoding
dec_count_o  output  CNT_W  number of output handshakes, saturating

Behaviour:
- Reset: all outputs 0 except inst_ready_o, which is 1 from the first cycle after reset. Buffer is emptied; counter is cleared.
- Accept rule: accept when inst_valid_i && inst_ready_o && !flush_i.
- Latency: an accepted instruction appears on dec_* in the next cycle if the buffer was empty.
- Buffer: 2-entry FIFO; the head drives dec_*.
  - inst_ready_o is registered and equals "occupancy after this cycle's updates < 2".
  - Simultaneous accept and output handshake with occupancy 2 is not possible (ready is already low).
  - With occupancy 1, a simultaneous accept and pop keeps occupancy at 1.
- Output handshake: dec_valid_o && dec_ready_i pops the head. dec_* stay stable while dec_valid_o=1 and dec_ready_i=0.
- Order: strictly preserved.
- Immediates (sign bit is inst[31]):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - R, custom-0 and illegal: 0.
- Legal opcodes: 0x33, 0x13, 0x23, 0x63, 0x17, 0x6F, 0x0B. Anything else is illegal.
- Further illegal conditions:
  - R: funct7 not 0x00/0x20, or funct7=0x20 with funct3 not 000/101.
  - I: funct3=001 with funct7≠0x00; funct3=101 with funct7 not 0x00/0x20.
  - S: funct3>010.
  - B: funct3 is 010 or 011.
  - custom-0: funct3≠000.
- Illegal entries still flow through the buffer with dec_illegal_o=1 and all field outputs 0 except dec_opcode_o and dec_pc_o.
- Flush: buffer is empty in the next cycle and dec_valid_o=0. An instruction presented in the flush cycle is dropped. inst_ready_o=1 in the next cycle. The counter is unchanged.
- Counter: increments on each output handshake, including illegal entries. It saturates at 2^CNT_W-1 and is cleared only by rst.
- Reset mid-operation: buffered entries are lost; outputs return to their reset values in the next cycle.

Test Plan:
- inst_i=0xFFF10093 (ADDI x1,x2,-1), pc_i=0x100, dec_ready_i=1 -> next cycle dec_valid_o=1, opcode 0x13, rd 1, rs1 2, funct3 0, imm 0xFFFFFFFF, pc 0x100, illegal 0, count 1.
- inst_i=0xFE532E23 (SW x5,-4(x6)) -> imm 0xFFFFFFFC, rs1 6, rs2 5, funct3 2, rd 0. Then inst_i=0x001000EF (JAL x1,+2048) -> imm 0x00000800, rd 1.
- dec_ready_i=0, three back-to-back valid instructions A,B,C -> A and B accepted; inst_ready_o=0 from the cycle after B is accepted; C is held. Set dec_ready_i=1 -> A, B, C appear on consecutive cycles in order, and count reaches 3.
- inst_i=0x00000000 -> illegal 1, imm 0, count increments. inst_i=0x40001013 (SLLI with funct7=0x20) -> illegal 1. inst_i=0x0000200B (custom-0, funct3=2) -> illegal 1.
- Two entries buffered with dec_ready_i=0, then assert flush_i together with a new valid instruction -> next cycle dec_valid_o=0, inst_ready_o=1, count unchanged, and the new instruction never appears.
- rst asserted while holding 2 entries -> next cycle all outputs 0 and count 0; inst_ready_o=1 in the cycle after rst deasserts. Separately, force count to 0xFFFF and complete 2 more handshakes -> count stays 0xFFFF.
